bram_arbiter: RTL and testbench

//  Shares one single-port bram between instruction fetch (IF, read-only) and data access (D, read/write, byte strobes).
//  - Round-robin arbitration, one grant per cycle.
//  - Byte-lane merge for partial writes.
//  - Registered, backpressurable per-port responses.
//  - Sits between core fetch/LSU and the bram instance; drives its addr/wen/din and samples its combinational dout.

---
 rtl/bram_arb_pkg.sv | 26 ++
 rtl/bram_resp_slot.sv | 43 ++++
 rtl/bram_arbiter.sv | 136 +++++++++++++
 tb/tb_bram_arbiter.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_arb_pkg.sv
// ============================================================================
// Module : bram_arb_pkg
// Brief  : Shared types and helpers for the IF/D bram arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bram_arb_pkg;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // One byte lane of a partial-write merge: strobe selects the new byte.
    function automatic logic [7:0] byte_merge(
        input logic [7:0] old_byte,
        input logic [7:0] new_byte,
        input logic       strb
    );
        return strb ? new_byte : old_byte;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bram_resp_slot.sv
// ============================================================================
// Module : bram_resp_slot
// Brief  : One-entry registered response buffer with valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_resp_slot #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  resp_ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  free_next
);

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;

    // A load in the same cycle as a handshake refills the slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (load) begin
            r_valid <= 1'b1;
            r_data  <= load_data;
        end else if (r_valid && resp_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign valid     = r_valid;
    assign data      = r_data;
    assign free_next = !r_valid || resp_ready;

endmodule

`default_nettype wire

// File: rtl/bram_arbiter.sv
// ============================================================================
// Module : bram_arbiter
// Brief  : Round-robin share of one single-port bram between fetch and LSU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bram_arbiter
    import bram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CAPACITY   = 1024,
    parameter int ADDR_WIDTH = $clog2((CAPACITY << 3) / DATA_WIDTH),
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int OFFS       = $clog2(STRB_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  if_req_valid,
    output logic                  if_req_ready,
    input  logic [31:0]           if_req_addr,
    output logic                  if_resp_valid,
    input  logic                  if_resp_ready,
    output logic [DATA_WIDTH-1:0] if_resp_data,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [31:0]           d_req_addr,
    input  logic                  d_req_wen,
    input  logic [STRB_WIDTH-1:0] d_req_wstrb,
    input  logic [DATA_WIDTH-1:0] d_req_wdata,
    output logic                  d_resp_valid,
    input  logic                  d_resp_ready,
    output logic [DATA_WIDTH-1:0] d_resp_data,

    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic                  bram_wen,
    output logic [DATA_WIDTH-1:0] bram_din,
    input  logic [DATA_WIDTH-1:0] bram_dout
);

    port_e                 r_last_grant;
    logic [ADDR_WIDTH-1:0] r_addr_hold;

    logic                  w_if_free;
    logic                  w_d_free;
    logic                  w_if_elig;
    logic                  w_d_elig;
    logic                  w_if_cand;
    logic                  w_d_cand;
    logic                  w_if_acc;
    logic                  w_d_acc;
    logic [ADDR_WIDTH-1:0] w_if_waddr;
    logic [ADDR_WIDTH-1:0] w_d_waddr;
    logic [ADDR_WIDTH-1:0] w_addr_mux;
    logic                  w_unused_addr;

    assign w_if_waddr    = if_req_addr[OFFS +: ADDR_WIDTH];
    assign w_d_waddr     = d_req_addr[OFFS +: ADDR_WIDTH];
    assign w_unused_addr = ^{if_req_addr, d_req_addr};

    // Holding off grants while reset is asserted keeps the bram untouched.
    assign w_if_elig = w_if_free && !rst;
    assign w_d_elig  = w_d_free && !rst;
    assign w_if_cand = if_req_valid && w_if_elig;
    assign w_d_cand  = d_req_valid && w_d_elig;

    assign if_req_ready = w_if_elig && (!w_d_cand || (r_last_grant == PORT_D));
    assign d_req_ready  = w_d_elig && (!w_if_cand || (r_last_grant == PORT_IF));

    assign w_if_acc = if_req_valid && if_req_ready;
    assign w_d_acc  = d_req_valid && d_req_ready;

    always_comb begin
        w_addr_mux = r_addr_hold;
        if (w_if_acc) begin
            w_addr_mux = w_if_waddr;
        end else if (w_d_acc) begin
            w_addr_mux = w_d_waddr;
        end
    end

    assign bram_addr = w_addr_mux;
    assign bram_wen  = w_d_acc && d_req_wen && (|d_req_wstrb);

    // Read-modify-write: unstrobed lanes are refilled from the current word.
    for (genvar i = 0; i < STRB_WIDTH; i++) begin : g_lane
        assign bram_din[8*i +: 8] = byte_merge(bram_dout[8*i +: 8],
                                               d_req_wdata[8*i +: 8],
                                               d_req_wstrb[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= PORT_D;
            r_addr_hold  <= '0;
        end else begin
            if (w_if_acc) begin
                r_last_grant <= PORT_IF;
            end else if (w_d_acc) begin
                r_last_grant <= PORT_D;
            end
            r_addr_hold <= w_addr_mux;
        end
    end

    bram_resp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_if_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (w_if_acc),
        .load_data  (bram_dout),
        .resp_ready (if_resp_ready),
        .valid      (if_resp_valid),
        .data       (if_resp_data),
        .free_next  (w_if_free)
    );

    bram_resp_slot #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_d_slot (
        .clk        (clk),
        .rst        (rst),
        .load       (w_d_acc),
        .load_data  (bram_dout),
        .resp_ready (d_resp_ready),
        .valid      (d_resp_valid),
        .data       (d_resp_data),
        .free_next  (w_d_free)
    );

endmodule

`default_nettype wire

// File: tb/tb_bram_arbiter.sv
// ============================================================================
// Module : tb_bram_arbiter
// Brief  : Directed bench for bram_arbiter with a bram array and a reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bram_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic [31:0]   if_req_addr;
    logic [DW-1:0] if_resp_data;
    logic          d_req_valid, d_req_ready, d_req_wen, d_resp_valid, d_resp_ready;
    logic [31:0]   d_req_addr;
    logic [SW-1:0] d_req_wstrb;
    logic [DW-1:0] d_req_wdata, d_resp_data;
    logic [AW-1:0] bram_addr;
    logic          bram_wen;
    logic [DW-1:0] bram_din, bram_dout;

    always #5 clk = ~clk;

    bram_arbiter #(
        .DATA_WIDTH (DW),
        .CAPACITY   (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .if_req_valid  (if_req_valid),
        .if_req_ready  (if_req_ready),
        .if_req_addr   (if_req_addr),
        .if_resp_valid (if_resp_valid),
        .if_resp_ready (if_resp_ready),
        .if_resp_data  (if_resp_data),
        .d_req_valid   (d_req_valid),
        .d_req_ready   (d_req_ready),
        .d_req_addr    (d_req_addr),
        .d_req_wen     (d_req_wen),
        .d_req_wstrb   (d_req_wstrb),
        .d_req_wdata   (d_req_wdata),
        .d_resp_valid  (d_resp_valid),
        .d_resp_ready  (d_resp_ready),
        .d_resp_data   (d_resp_data),
        .bram_addr     (bram_addr),
        .bram_wen      (bram_wen),
        .bram_din      (bram_din),
        .bram_dout     (bram_dout)
    );

    // The bram itself: combinational read, write at the rising edge.
    logic [31:0] mem [0:255];
    assign bram_dout = mem[bram_addr];
    always @(posedge clk) if (bram_wen === 1'b1) mem[bram_addr] <= bram_din;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'hA5000000 + 32'(i) * 32'h00010001;
    endfunction

    function automatic logic [7:0] word_of(input logic [31:0] a);
        return a[9:2];
    endfunction

    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [3:0] strb);
        logic [31:0] mask;
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = strb[b] ? 8'hFF : 8'h00;
        return (old & ~mask) | (wd & mask);
    endfunction

    // Reference model state: expected response slots, memory image, arbitration history.
    logic [31:0] ref_mem [0:255];
    bit          m_if_v, m_d_v, m_last_d, rst_seen;
    logic [31:0] m_if_d, m_d_d;
    logic [7:0]  m_addr;

    always @(posedge rst) rst_seen = 1'b1;

    task automatic model_step();
        bit          e_if, e_d, c_if, c_d, r_if, r_d, a_if, a_d, e_wen;
        logic [7:0]  e_addr;
        logic [31:0] old;
        if (rst || rst_seen) begin
            m_if_v = 0; m_d_v = 0; m_if_d = '0; m_d_d = '0;
            m_last_d = 1; m_addr = '0; rst_seen = 0;
        end
        if (rst) begin
            chk("rst_if_valid", 32'(if_resp_valid), 32'd0);
            chk("rst_d_valid", 32'(d_resp_valid), 32'd0);
            chk("rst_if_data", if_resp_data, 32'd0);
            chk("rst_d_data", d_resp_data, 32'd0);
            chk("rst_wen", 32'(bram_wen), 32'd0);
            chk("rst_addr", 32'(bram_addr), 32'd0);
            return;
        end
        chk("m_if_resp_valid", 32'(if_resp_valid), 32'(m_if_v));
        chk("m_d_resp_valid", 32'(d_resp_valid), 32'(m_d_v));
        if (m_if_v) chk("m_if_resp_data", if_resp_data, m_if_d);
        if (m_d_v) chk("m_d_resp_data", d_resp_data, m_d_d);

        e_if = !m_if_v || if_resp_ready;
        e_d  = !m_d_v || d_resp_ready;
        c_if = if_req_valid && e_if;
        c_d  = d_req_valid && e_d;
        r_if = e_if && (!c_d || m_last_d);
        r_d  = e_d && (!c_if || !m_last_d);
        chk("m_if_req_ready", 32'(if_req_ready), 32'(r_if));
        chk("m_d_req_ready", 32'(d_req_ready), 32'(r_d));

        a_if   = if_req_valid && r_if;
        a_d    = d_req_valid && r_d;
        e_addr = a_if ? word_of(if_req_addr) : (a_d ? word_of(d_req_addr) : m_addr);
        e_wen  = a_d && d_req_wen && (d_req_wstrb != 4'd0);
        chk("m_bram_addr", 32'(bram_addr), 32'(e_addr));
        chk("m_bram_wen", 32'(bram_wen), 32'(e_wen));
        if (e_wen) chk("m_bram_din", bram_din, merge_model(ref_mem[e_addr], d_req_wdata, d_req_wstrb));

        old = ref_mem[e_addr];
        if (a_if) begin m_if_v = 1; m_if_d = old; end
        else if (m_if_v && if_resp_ready) m_if_v = 0;
        if (a_d) begin m_d_v = 1; m_d_d = old; end
        else if (m_d_v && d_resp_ready) m_d_v = 0;
        if (e_wen) ref_mem[e_addr] = merge_model(old, d_req_wdata, d_req_wstrb);
        if (a_if) m_last_d = 0;
        else if (a_d) m_last_d = 1;
        m_addr = e_addr;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #4;
            model_step();
        end
    end

    task automatic idle();
        if_req_valid = 0; d_req_valid = 0; d_req_wen = 0; d_req_wstrb = '0;
    endtask

    int          ni, nd, wen_cnt;
    logic [7:0]  seq;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = init_word(i);
            ref_mem[i] = init_word(i);
        end
        rst = 1; idle();
        if_req_addr = '0; d_req_addr = '0; d_req_wdata = '0;
        if_resp_ready = 1; d_resp_ready = 1;
        repeat (3) @(negedge clk);
        rst = 0;

        // Full write then IF read of the same word
        @(negedge clk);
        d_req_valid = 1; d_req_addr = 32'h10; d_req_wen = 1; d_req_wstrb = 4'hF; d_req_wdata = 32'hDEADBEEF;
        #4 chk("t1_d_ready", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        idle(); if_req_valid = 1; if_req_addr = 32'h10;
        #4;
        chk("t1_d_resp_valid", 32'(d_resp_valid), 32'd1);
        chk("t1_d_resp_prewrite", d_resp_data, init_word(4));
        chk("t1_if_ready", 32'(if_req_ready), 32'd1);
        @(negedge clk);
        idle();
        #4;
        chk("t1_if_resp_valid", 32'(if_resp_valid), 32'd1);
        chk("t1_if_resp_data", if_resp_data, 32'hDEADBEEF);

        // Partial write of byte 1 followed back-to-back by a read
        @(negedge clk);
        d_req_valid = 1; d_req_addr = 32'h10; d_req_wen = 1; d_req_wstrb = 4'b0010; d_req_wdata = 32'h0000AA00;
        #4 chk("t2_d_ready_wr", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        d_req_wen = 0; d_req_wstrb = '0;
        #4;
        chk("t2_wr_resp", d_resp_data, 32'hDEADBEEF);
        chk("t2_d_ready_rd", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        idle();
        #4 chk("t2_rd_resp", d_resp_data, 32'hDEADAAEF);

        // Both ports requesting for 8 cycles straight after reset
        @(negedge clk); rst = 1;
        @(negedge clk); rst = 0;
        ni = 0; nd = 0; wen_cnt = 0; seq = '0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if_req_valid = 1; if_req_addr = 32'h100 + 32'(4 * ni);
            d_req_valid = 1; d_req_wen = 1; d_req_wstrb = 4'hF;
            d_req_addr = 32'h80 + 32'(4 * nd); d_req_wdata = 32'h11110000 + 32'(nd);
            #4;
            if (bram_wen === 1'b1) wen_cnt++;
            if (if_req_ready === 1'b1) ni++;
            if (d_req_ready === 1'b1) begin nd++; seq[k] = 1'b1; end
        end
        @(negedge clk); idle();
        chk("t3_grant_seq", 32'(seq), 32'hAA);
        chk("t3_if_grants", 32'(ni), 32'd4);
        chk("t3_d_grants", 32'(nd), 32'd4);
        chk("t3_wen_count", 32'(wen_cnt), 32'd4);

        // IF response stalled: IF blocked, D flows, IF resumes on release
        @(negedge clk);
        if_resp_ready = 0; if_req_valid = 1; if_req_addr = 32'h20;
        #4 chk("t4_if_first_ready", 32'(if_req_ready), 32'd1);
        @(negedge clk);
        if_req_addr = 32'h24; d_req_valid = 1; d_req_wen = 0; d_req_addr = 32'h30;
        for (int k = 0; k < 5; k++) begin
            #4;
            chk("t4_if_blocked", 32'(if_req_ready), 32'd0);
            chk("t4_if_data_hold", if_resp_data, init_word(8));
            chk("t4_d_flows", 32'(d_req_ready), 32'd1);
            @(negedge clk);
        end
        if_resp_ready = 1;
        #4;
        chk("t4_if_resumes", 32'(if_req_ready), 32'd1);
        chk("t4_d_loses", 32'(d_req_ready), 32'd0);
        @(negedge clk); idle();
        repeat (2) @(negedge clk);

        // Address wrap and zero-strobe write
        d_req_valid = 1; d_req_addr = 32'h400; d_req_wen = 0;
        #4 chk("t5_d_ready", 32'(d_req_ready), 32'd1);
        @(negedge clk);
        d_req_addr = 32'h40; d_req_wen = 1; d_req_wstrb = 4'h0; d_req_wdata = 32'hFFFFFFFF;
        #4;
        chk("t5_wrap_data", d_resp_data, init_word(0));
        chk("t5_zero_strb_ready", 32'(d_req_ready), 32'd1);
        chk("t5_zero_strb_wen", 32'(bram_wen), 32'd0);
        @(negedge clk);
        d_req_wen = 0; d_req_wstrb = '0;
        #4;
        chk("t5_zero_strb_resp_valid", 32'(d_resp_valid), 32'd1);
        chk("t5_zero_strb_resp", d_resp_data, init_word(16));
        @(negedge clk); idle();
        #4 chk("t5_readback", d_resp_data, init_word(16));

        // Async reset with both response slots full
        @(negedge clk);
        if_resp_ready = 0; d_resp_ready = 0;
        if_req_valid = 1; if_req_addr = 32'h10; d_req_valid = 1; d_req_addr = 32'h80;
        #4;
        chk("t6_tie_if", 32'(if_req_ready), 32'd1);
        chk("t6_tie_d", 32'(d_req_ready), 32'd0);
        @(negedge clk);
        #4 chk("t6_d_second", 32'(d_req_ready), 32'd1);
        @(negedge clk); idle();
        #4;
        chk("t6_if_full", 32'(if_resp_valid), 32'd1);
        chk("t6_d_full", 32'(d_resp_valid), 32'd1);
        @(posedge clk);
        #2 rst = 1;
        #1;
        chk("t6_async_if_valid", 32'(if_resp_valid), 32'd0);
        chk("t6_async_d_valid", 32'(d_resp_valid), 32'd0);
        chk("t6_async_wen", 32'(bram_wen), 32'd0);
        chk("t6_async_addr", 32'(bram_addr), 32'd0);
        #1 rst = 0;
        @(negedge clk);
        if_resp_ready = 1; d_resp_ready = 1;
        if_req_valid = 1; if_req_addr = 32'h10; d_req_valid = 1; d_req_addr = 32'h80;
        #4;
        chk("t6_post_tie_if", 32'(if_req_ready), 32'd1);
        chk("t6_post_tie_d", 32'(d_req_ready), 32'd0);
        @(negedge clk);
        if_req_valid = 0;
        #4;
        chk("t6_mem_kept_if", if_resp_data, 32'hDEADAAEF);
        chk("t6_d_ready", 32'(d_req_ready), 32'd1);
        @(negedge clk); idle();
        #4 chk("t6_mem_kept_d", d_resp_data, 32'h11110000);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
